// File: rtl/cpu_run_if.sv
// Run-controller bus: start/pc/breakpoint inputs from the host side, run status back to it.
// master = host or bench driving the controller, slave = cpu_run_ctrl.
interface cpu_run_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [31:0]      pc;
    logic [31:0]      bp_pc;
    logic             bp_en;
    logic             cpu_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, pc, bp_pc, bp_en,
        input  cpu_rst, running, done, timeout, bp_hit, cycle_count
    );

    modport slave (
        input  start, pc, bp_pc, bp_en,
        output cpu_rst, running, done, timeout, bp_hit, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the mips core: holds reset, counts cycles, detects a PC self-loop halt,
// drains the pipeline and reports done or timeout. Optional breakpoint stop: RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int HALT_REPEAT  = 3,
    parameter int DRAIN_CYCLES = 5,
    parameter int MAX_CYCLES   = 100000,
    parameter int CNT_W        = 32
) (
    input logic     clk,
    input logic     reset,
    cpu_run_if.slave bus
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(HALT_REPEAT + 1);
    localparam int RW = $clog2(MAX_CYCLES + 1);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, HOLD, RUN, DRAIN, DONE, TIMEOUT} state_e;

    state_e           state_q;
    logic             cpu_rst_q, running_q, done_q, timeout_q, bp_hit_q, bp_seen_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hold_q;
    logic [SW-1:0]    same_q, same_d;
    logic [RW-1:0]    run_q, run_d;
    logic [DW-1:0]    drain_q;
    logic [31:0]      pc_q;
    logic             halt_d, bp_d, stop_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Previous-cycle pc; validity is qualified by run_q, so no reset needed.
    always_ff @(posedge clk) begin
        pc_q <= bus.pc;
    end

    always_comb begin
        cnt_d  = sat_inc(cnt_q);
        run_d  = run_q + RW'(1);
        same_d = SW'(1);
        if (run_q != '0 && bus.pc == pc_q) same_d = same_q + SW'(1);
        halt_d = (same_d >= SW'(HALT_REPEAT));
`ifdef RUN_CTRL_BREAKPOINT_EN
        bp_d   = bus.bp_en && (bus.pc == bus.bp_pc);
`else
        bp_d   = 1'b0;
`endif
        stop_d = halt_d | bp_d;
    end

`ifndef RUN_CTRL_BREAKPOINT_EN
    logic unused_bp;
    assign unused_bp = ^{bus.bp_en, bus.bp_pc};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            bp_seen_q <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            same_q    <= '0;
            run_q     <= '0;
            drain_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, TIMEOUT: begin
                    if (bus.start) begin
                        state_q   <= HOLD;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        bp_hit_q  <= 1'b0;
                        cnt_q     <= '0;
                        hold_q    <= '0;
                    end
                end
                HOLD: begin
                    if (hold_q == HW'(RST_CYCLES - 1)) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                        running_q <= 1'b1;
                        run_q     <= '0;
                        same_q    <= '0;
                        bp_seen_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                RUN: begin
                    cnt_q  <= cnt_d;
                    run_q  <= run_d;
                    same_q <= same_d;
                    // Halt/breakpoint take priority over the timeout limit.
                    if (stop_d) begin
                        bp_seen_q <= bp_d;
                        if (DRAIN_CYCLES == 0) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            bp_hit_q  <= bp_d;
                        end else begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end else if (run_d == RW'(MAX_CYCLES)) begin
                        state_q   <= TIMEOUT;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_d;
                    if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        bp_hit_q  <= bp_seen_q;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: main instance (MAX_CYCLES=20) plus a 4-bit counter
// instance sharing its inputs to exercise cycle_count saturation.
module tb_cpu_run_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cpu_run_if #(.CNT_W(32)) bus_a ();
    cpu_run_if #(.CNT_W(4))  bus_s ();

    assign bus_s.start = bus_a.start;
    assign bus_s.pc    = bus_a.pc;
    assign bus_s.bp_pc = bus_a.bp_pc;
    assign bus_s.bp_en = bus_a.bp_en;

    cpu_run_ctrl #(.MAX_CYCLES(20)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    cpu_run_ctrl #(.MAX_CYCLES(20), .CNT_W(4)) dut_sat (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] hp [5];

    initial begin
        checks   = 0;
        failures = 0;
        hp = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
        reset        = 1'b0;
        bus_a.start  = 1'b0;
        bus_a.pc     = 32'h0;
        bus_a.bp_pc  = 32'h300c;
        bus_a.bp_en  = 1'b0;

        repeat (3) tick();
        chk("rst_cpu_rst", 32'(bus_a.cpu_rst), 1);
        chk("rst_running", 32'(bus_a.running), 0);
        chk("rst_done",    32'(bus_a.done), 0);
        chk("rst_timeout", 32'(bus_a.timeout), 0);
        chk("rst_bp_hit",  32'(bus_a.bp_hit), 0);
        chk("rst_count",   bus_a.cycle_count, 0);

        reset = 1'b1;
        tick();
        chk("idle_cpu_rst", 32'(bus_a.cpu_rst), 1);

        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_cpu_rst", 32'(bus_a.cpu_rst), 1);
            chk("hold_running", 32'(bus_a.running), 0);
            tick();
        end
        chk("run_cpu_rst", 32'(bus_a.cpu_rst), 0);
        chk("run_running", 32'(bus_a.running), 1);

        // Halt: three identical pcs in a row
        for (int i = 0; i < 5; i++) begin
            bus_a.pc = hp[i];
            tick();
        end
        chk("drain_running", 32'(bus_a.running), 1);
        chk("drain_count",   bus_a.cycle_count, 5);
        chk("drain_done",    32'(bus_a.done), 0);
        repeat (4) tick();
        chk("drain4_done",  32'(bus_a.done), 0);
        chk("drain4_count", bus_a.cycle_count, 9);
        tick();
        chk("done_done",     32'(bus_a.done), 1);
        chk("done_running",  32'(bus_a.running), 0);
        chk("done_cpu_rst",  32'(bus_a.cpu_rst), 0);
        chk("done_timeout",  32'(bus_a.timeout), 0);
        chk("done_bp_hit",   32'(bus_a.bp_hit), 0);
        chk("done_count",    bus_a.cycle_count, 10);
        chk("sat_done_count", 32'(bus_s.cycle_count), 10);
        repeat (2) tick();
        chk("done_frozen_count", bus_a.cycle_count, 10);
        chk("done_level",        32'(bus_a.done), 1);

        // Restart from DONE
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("restart_done",    32'(bus_a.done), 0);
        chk("restart_cpu_rst", 32'(bus_a.cpu_rst), 1);
        chk("restart_count",   bus_a.cycle_count, 0);
        repeat (3) tick();
        chk("restart_hold4_cpu_rst", 32'(bus_a.cpu_rst), 1);
        tick();
        chk("restart_run_running", 32'(bus_a.running), 1);
        chk("restart_run_cpu_rst", 32'(bus_a.cpu_rst), 0);

        // Linear pc until timeout; a start pulse mid-run must be ignored
        for (int i = 0; i < 20; i++) begin
            bus_a.pc    = 32'h3000 + 32'(4 * i);
            bus_a.start = (i == 5);
            tick();
            if (i == 5) begin
                chk("midrun_start_running", 32'(bus_a.running), 1);
                chk("midrun_start_count",   bus_a.cycle_count, 6);
            end
            if (i == 18) begin
                chk("pre_timeout_flag",  32'(bus_a.timeout), 0);
                chk("pre_timeout_count", bus_a.cycle_count, 19);
            end
        end
        bus_a.start = 1'b0;
        chk("timeout_flag",    32'(bus_a.timeout), 1);
        chk("timeout_count",   bus_a.cycle_count, 20);
        chk("timeout_done",    32'(bus_a.done), 0);
        chk("timeout_running", 32'(bus_a.running), 0);
        chk("sat_timeout_flag",  32'(bus_s.timeout), 1);
        chk("sat_timeout_count", 32'(bus_s.cycle_count), 32'hf);

        // Async reset while draining
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("restart_timeout_drop", 32'(bus_a.timeout), 0);
        repeat (4) tick();
        bus_a.pc = 32'h4000;
        repeat (3) tick();
        chk("rd_drain_running", 32'(bus_a.running), 1);
        chk("rd_drain_count",   bus_a.cycle_count, 3);
        tick();
        chk("rd_drain_count2",  bus_a.cycle_count, 4);
        #2 reset = 1'b0;
        #1;
        chk("rd_cpu_rst", 32'(bus_a.cpu_rst), 1);
        chk("rd_running", 32'(bus_a.running), 0);
        chk("rd_done",    32'(bus_a.done), 0);
        chk("rd_count",   bus_a.cycle_count, 0);
        tick();
        chk("rd_hold_cpu_rst", 32'(bus_a.cpu_rst), 1);
        reset = 1'b1;
        tick();

        // Breakpoint at 0x300c on a linear pc stream
        bus_a.bp_en = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            bus_a.pc = 32'h3000 + 32'(4 * i);
            tick();
        end
        chk("bp_running", 32'(bus_a.running), 1);
        chk("bp_count",   bus_a.cycle_count, 4);
        for (int i = 0; i < 5; i++) begin
            bus_a.pc = 32'h3010 + 32'(4 * i);
            tick();
        end
`ifdef RUN_CTRL_BREAKPOINT_EN
        chk("bp_done",    32'(bus_a.done), 1);
        chk("bp_hit",     32'(bus_a.bp_hit), 1);
        chk("bp_running_end", 32'(bus_a.running), 0);
`else
        chk("bp_done",    32'(bus_a.done), 0);
        chk("bp_hit",     32'(bus_a.bp_hit), 0);
        chk("bp_running_end", 32'(bus_a.running), 1);
`endif
        chk("bp_count_end", bus_a.cycle_count, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
